// File: rtl/goomba_spawner_pkg.sv
// Shared types and constants for the goomba spawner: spawn table layout,
// the level table itself, playfield geometry and the controller states.
package goomba_pkg;

   typedef struct packed {
      logic [7:0] trig_col;
      logic [9:0] y;
   } spawn_entry_t;

   localparam logic [7:0] SPAWN_END      = 8'hFF;
   localparam logic [7:0] COL_MAX        = 8'hFE;
   localparam logic [9:0] X_MAX          = 10'd519;
   localparam logic [9:0] GOOMBA_HALF_W  = 10'd20;
   localparam logic [9:0] Y_GROUND       = 10'd400;
   localparam logic [9:0] Y_PIPE         = 10'd380;
   localparam logic [9:0] Y_BLOCK        = 10'd360;
   localparam logic [9:0] Y_LEDGE        = 10'd340;
   localparam int         LEVEL_DEPTH    = 8;

   typedef spawn_entry_t [LEVEL_DEPTH-1:0] level_table_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_COL,
      ST_ISSUE,
      ST_EXHAUSTED
   } spawn_state_e;

   // Entries must stay sorted by trig_col; unused slots hold the end sentinel.
   function automatic level_table_t build_level_table();
      level_table_t t;
      for (int i = 0; i < LEVEL_DEPTH; i++) begin
         t[i] = '{trig_col: SPAWN_END, y: 10'd0};
      end
      t[0] = '{trig_col: 8'd0, y: Y_GROUND};
      t[1] = '{trig_col: 8'd2, y: Y_PIPE};
      t[2] = '{trig_col: 8'd2, y: Y_BLOCK};
      t[3] = '{trig_col: 8'd3, y: Y_LEDGE};
      return t;
   endfunction

   localparam level_table_t LEVEL_TABLE = build_level_table();

endpackage

// File: rtl/goomba_spawner_if.sv
// Slot-side bus between the spawner (master) and the pool of goomba instances
// (slave). start_vec/kill_vec are single-cycle pulses; spawnX/spawnY are
// meaningful only while a start_vec bit is high and hold otherwise.
interface goomba_spawner_if #(
   parameter int NUM_SLOTS = 4
);
   logic [NUM_SLOTS-1:0] alive_vec;
   logic [NUM_SLOTS-1:0] kill_mario_vec;
   logic [NUM_SLOTS-1:0] start_vec;
   logic [NUM_SLOTS-1:0] kill_vec;
   logic [9:0]           spawnX;
   logic [9:0]           spawnY;

   modport master (
      input  alive_vec, kill_mario_vec,
      output start_vec, kill_vec, spawnX, spawnY
   );

   modport slave (
      output alive_vec, kill_mario_vec,
      input  start_vec, kill_vec, spawnX, spawnY
   );
endinterface

// File: rtl/goomba_spawner_slot_allocator.sv
// Lowest-free-slot priority encoder: one-hot grant of the least significant
// set bit of free_i, plus a flag saying any slot is free at all.
module slot_allocator #(
   parameter int N = 4
) (
   input  logic [N-1:0] free_i,
   output logic [N-1:0] grant_o,
   output logic         valid_o
);
   // x & -x isolates the lowest set bit.
   assign grant_o = free_i & (~free_i + N'(1));
   assign valid_o = |free_i;
endmodule

// File: rtl/goomba_spawner.sv
// Level-side goomba spawner: tracks the scroll column, walks the spawn table
// and assigns each due entry to the lowest free slot, dropping stale entries.
module goomba_spawner
   import goomba_pkg::*;
#(
   parameter int         NUM_SLOTS   = 4,
   parameter int         SPAWN_COUNT = 8,
   parameter logic [9:0] SPAWN_X     = X_MAX - GOOMBA_HALF_W,
   parameter int         MAX_LAG     = 2
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                level_start,
   input  logic                Shift,
   goomba_spawner_if.master    slots,
   output logic                mario_hit,
   output logic [7:0]          column,
   output logic                done,
   output logic [3:0]          dropped_count,
   output spawn_state_e        state_dbg_o
);
   localparam int         IDX_W     = $clog2(SPAWN_COUNT + 1);
   localparam logic [7:0] LAG_LIMIT = 8'(MAX_LAG);

   spawn_state_e         state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   spawn_entry_t         entry_q, entry_d, rom_entry;
   logic [7:0]           column_q, column_d;
   logic [NUM_SLOTS-1:0] reserved_q, reserved_d;
   logic [3:0]           dropped_q, dropped_d;
   logic                 done_q, done_d;
   logic [NUM_SLOTS-1:0] start_q, start_d;
   logic [NUM_SLOTS-1:0] kill_q, kill_d;
   logic [9:0]           spawnx_q, spawnx_d;
   logic [9:0]           spawny_q, spawny_d;
   logic                 hit_q;
   logic [NUM_SLOTS-1:0] free, grant;
   logic                 grant_valid;
   logic [7:0]           lag;

   // Indices past SPAWN_COUNT read back as the end sentinel.
   always_comb begin
      rom_entry = '{trig_col: SPAWN_END, y: 10'd0};
      for (int i = 0; i < SPAWN_COUNT; i++) begin
         if (idx_q == IDX_W'(i)) rom_entry = LEVEL_TABLE[i];
      end
   end

   assign free = ~slots.alive_vec & ~reserved_q;
   assign lag  = column_q - entry_q.trig_col;

   slot_allocator #(.N(NUM_SLOTS)) u_alloc (
      .free_i  (free),
      .grant_o (grant),
      .valid_o (grant_valid)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      entry_d    = entry_q;
      column_d   = column_q;
      reserved_d = reserved_q & ~slots.alive_vec;
      dropped_d  = dropped_q;
      done_d     = done_q;
      start_d    = '0;
      kill_d     = '0;
      spawnx_d   = spawnx_q;
      spawny_d   = spawny_q;

      if (level_start) begin
         state_d    = ST_FETCH;
         idx_d      = '0;
         column_d   = 8'd0;
         reserved_d = '0;
         dropped_d  = 4'd0;
         done_d     = 1'b0;
         kill_d     = '1;
      end else begin
         if (Shift && state_q != ST_IDLE && column_q != COL_MAX) column_d = column_q + 8'd1;
         unique case (state_q)
            ST_FETCH: begin
               entry_d = rom_entry;
               if (rom_entry.trig_col == SPAWN_END) begin
                  done_d  = 1'b1;
                  state_d = ST_EXHAUSTED;
               end else begin
                  state_d = ST_WAIT_COL;
               end
            end
            ST_WAIT_COL: if (column_q >= entry_q.trig_col) state_d = ST_ISSUE;
            ST_ISSUE: begin
               // Reserve the granted slot until its alive flag catches up.
               if (grant_valid) begin
                  start_d    = grant;
                  spawnx_d   = SPAWN_X;
                  spawny_d   = entry_q.y;
                  reserved_d = reserved_d | grant;
                  idx_d      = idx_q + IDX_W'(1);
                  state_d    = ST_FETCH;
               end else if (lag > LAG_LIMIT) begin
                  if (dropped_q != 4'hF) dropped_d = dropped_q + 4'd1;
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_FETCH;
               end
            end
            ST_IDLE, ST_EXHAUSTED: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         entry_q    <= '0;
         column_q   <= 8'd0;
         reserved_q <= '0;
         dropped_q  <= 4'd0;
         done_q     <= 1'b0;
         start_q    <= '0;
         kill_q     <= '0;
         spawnx_q   <= 10'd0;
         spawny_q   <= 10'd0;
         hit_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         entry_q    <= entry_d;
         column_q   <= column_d;
         reserved_q <= reserved_d;
         dropped_q  <= dropped_d;
         done_q     <= done_d;
         start_q    <= start_d;
         kill_q     <= kill_d;
         spawnx_q   <= spawnx_d;
         spawny_q   <= spawny_d;
         hit_q      <= |(slots.kill_mario_vec & slots.alive_vec);
      end
   end

   assign slots.start_vec = start_q;
   assign slots.kill_vec  = kill_q;
   assign slots.spawnX    = spawnx_q;
   assign slots.spawnY    = spawny_q;
   assign mario_hit       = hit_q;
   assign column          = column_q;
   assign done            = done_q;
   assign dropped_count   = dropped_q;
   assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_goomba_spawner.sv
// Bench for goomba_spawner: a cycle table for the first spawn and mario_hit,
// then hand-written sequences with a small goomba-pool model and start queue.
module tb_goomba_spawner;
   import goomba_pkg::*;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         level_start;
   logic         Shift;
   logic         mario_hit;
   logic [7:0]   column;
   logic         done;
   logic [3:0]   dropped_count;
   spawn_state_e state_dbg;

   goomba_spawner_if #(.NUM_SLOTS(4)) slots();

   goomba_spawner #(
      .NUM_SLOTS   (4),
      .SPAWN_COUNT (8),
      .SPAWN_X     (10'd499),
      .MAX_LAG     (2)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .level_start   (level_start),
      .Shift         (Shift),
      .slots         (slots),
      .mario_hit     (mario_hit),
      .column        (column),
      .done          (done),
      .dropped_count (dropped_count),
      .state_dbg_o   (state_dbg)
   );

   always #5 Clk = ~Clk;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [13:0] exp_q[$];
   logic        model_en   = 1'b0;
   logic        sb_en      = 1'b0;
   logic [3:0]  hold_mask  = 4'd0;
   logic [3:0]  pend_start = 4'd0;
   logic [3:0]  pend_kill  = 4'd0;
   logic [3:0]  prev_start = 4'd0;

   typedef struct {
      logic       ls;
      logic       sh;
      logic [3:0] alive;
      logic [3:0] kmv;
      logic [3:0] exp_start;
      logic [3:0] exp_kill;
      logic [9:0] exp_x;
      logic [9:0] exp_y;
      logic       exp_hit;
      logic [7:0] exp_col;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: goomba pool reacts to last cycle's start/kill, then starts are scored.
   task automatic tick();
      logic [13:0] e;
      @(posedge Clk);
      #1;
      if (model_en) slots.alive_vec = (slots.alive_vec | (pend_start & ~hold_mask)) & ~pend_kill;
      pend_start = slots.start_vec;
      pend_kill  = slots.kill_vec;
      if (sb_en && slots.start_vec != 4'd0) begin
         chk("start_gap", 32'(prev_start), 32'd0);
         chk("spawn_x", 32'(slots.spawnX), 32'd499);
         if (exp_q.size() == 0) begin
            chk("start_unexpected", 32'({slots.start_vec, slots.spawnY}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("start_slot_y", 32'({slots.start_vec, slots.spawnY}), 32'(e));
         end
      end
      prev_start = slots.start_vec;
   endtask

   task automatic do_cycle(input logic ls, input logic sh);
      level_start = ls;
      Shift       = sh;
      tick();
      level_start = 1'b0;
      Shift       = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0);
   endtask

   initial begin
      // ls sh alive kmv | start kill x y hit col
      vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 10'd0,   10'd0,   1'b0, 8'd0};
      vecs[1]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 10'd0,   10'd0,   1'b0, 8'd0};
      vecs[2]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 10'd0,   10'd0,   1'b0, 8'd0};
      vecs[3]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 10'd499, 10'd400, 1'b0, 8'd0};
      vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 10'd499, 10'd400, 1'b0, 8'd0};
      vecs[5]  = '{1'b0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 10'd499, 10'd400, 1'b1, 8'd0};
      vecs[6]  = '{1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 10'd499, 10'd400, 1'b0, 8'd0};
      vecs[7]  = '{1'b0, 1'b0, 4'h1, 4'h4, 4'h0, 4'h0, 10'd499, 10'd400, 1'b0, 8'd0};
      vecs[8]  = '{1'b0, 1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 10'd499, 10'd400, 1'b1, 8'd0};
      vecs[9]  = '{1'b0, 1'b0, 4'h0, 4'h4, 4'h0, 4'h0, 10'd499, 10'd400, 1'b0, 8'd0};
      vecs[10] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 10'd499, 10'd400, 1'b0, 8'd1};

      Reset                = 1'b1;
      level_start          = 1'b0;
      Shift                = 1'b0;
      slots.alive_vec      = 4'd0;
      slots.kill_mario_vec = 4'd0;
      repeat (3) tick();
      Reset = 1'b0;
      chk("rst_start", 32'(slots.start_vec), 32'd0);
      chk("rst_kill", 32'(slots.kill_vec), 32'd0);
      chk("rst_x", 32'(slots.spawnX), 32'd0);
      chk("rst_y", 32'(slots.spawnY), 32'd0);
      chk("rst_hit", 32'(mario_hit), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dropped", 32'(dropped_count), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      do_cycle(1'b0, 1'b1);
      chk("idle_shift_col", 32'(column), 32'd0);
      chk("idle_state", 32'(state_dbg), 32'(ST_IDLE));

      // First spawn timing and mario_hit, cycle by cycle.
      for (int k = 0; k < 11; k++) begin
         slots.alive_vec      = vecs[k].alive;
         slots.kill_mario_vec = vecs[k].kmv;
         do_cycle(vecs[k].ls, vecs[k].sh);
         chk($sformatf("v%0d_start", k), 32'(slots.start_vec), 32'(vecs[k].exp_start));
         chk($sformatf("v%0d_kill", k), 32'(slots.kill_vec), 32'(vecs[k].exp_kill));
         chk($sformatf("v%0d_x", k), 32'(slots.spawnX), 32'(vecs[k].exp_x));
         chk($sformatf("v%0d_y", k), 32'(slots.spawnY), 32'(vecs[k].exp_y));
         chk($sformatf("v%0d_hit", k), 32'(mario_hit), 32'(vecs[k].exp_hit));
         chk($sformatf("v%0d_col", k), 32'(column), 32'(vecs[k].exp_col));
      end
      slots.kill_mario_vec = 4'd0;

      // Slot 0 died: entries at cols 2,2,3 land in slots 0,1,2.
      slots.alive_vec = 4'd0;
      model_en  = 1'b1;
      hold_mask = 4'd0;
      sb_en     = 1'b1;
      exp_q.push_back({4'b0001, 10'd380});
      exp_q.push_back({4'b0010, 10'd360});
      exp_q.push_back({4'b0100, 10'd340});
      do_cycle(1'b0, 1'b1);
      idle(8);
      do_cycle(1'b0, 1'b1);
      idle(8);
      chk("t2_drain", 32'(exp_q.size()), 32'd0);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_state", 32'(state_dbg), 32'(ST_EXHAUSTED));
      chk("t2_dropped", 32'(dropped_count), 32'd0);

      // Slot 0 alive lags: its reservation pushes later starts to other slots.
      hold_mask = 4'b0001;
      exp_q.push_back({4'b0001, 10'd400});
      exp_q.push_back({4'b0010, 10'd380});
      exp_q.push_back({4'b0100, 10'd360});
      exp_q.push_back({4'b1000, 10'd340});
      do_cycle(1'b1, 1'b0);
      do_cycle(1'b0, 1'b1);
      do_cycle(1'b0, 1'b1);
      idle(10);
      do_cycle(1'b0, 1'b1);
      idle(8);
      chk("t4_drain", 32'(exp_q.size()), 32'd0);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_col", 32'(column), 32'd3);

      // All slots busy: entries wait MAX_LAG columns, then drop.
      hold_mask = 4'b1111;
      do_cycle(1'b1, 1'b0);
      do_cycle(1'b0, 1'b0);
      slots.alive_vec = 4'b1111;
      idle(4);
      do_cycle(1'b0, 1'b1);
      do_cycle(1'b0, 1'b0);
      do_cycle(1'b0, 1'b1);
      idle(4);
      chk("t3_lag2_dropped", 32'(dropped_count), 32'd0);
      chk("t3_lag2_state", 32'(state_dbg), 32'(ST_ISSUE));
      do_cycle(1'b0, 1'b1);
      do_cycle(1'b0, 1'b0);
      chk("t3_lag3_dropped", 32'(dropped_count), 32'd1);
      idle(4);
      chk("t3_next_state", 32'(state_dbg), 32'(ST_ISSUE));
      do_cycle(1'b0, 1'b1);
      do_cycle(1'b0, 1'b0);
      do_cycle(1'b0, 1'b1);
      idle(10);
      chk("t3_dropped3", 32'(dropped_count), 32'd3);
      chk("t3_col5", 32'(column), 32'd5);
      chk("t3_done", 32'(done), 32'd0);

      // level_start wins over a same-cycle Shift.
      do_cycle(1'b1, 1'b1);
      chk("t6_col", 32'(column), 32'd0);
      chk("t6_kill", 32'(slots.kill_vec), 32'hF);
      chk("t6_dropped", 32'(dropped_count), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_state", 32'(state_dbg), 32'(ST_FETCH));
      do_cycle(1'b0, 1'b0);
      chk("t6_kill_once", 32'(slots.kill_vec), 32'd0);

      // Rerun with slot 2 free: the due entry goes there.
      slots.alive_vec = 4'b1011;
      exp_q.push_back({4'b0100, 10'd400});
      idle(6);
      chk("t3b_drain", 32'(exp_q.size()), 32'd0);

      sb_en = 1'b0;
      for (int i = 0; i < 260; i++) do_cycle(1'b0, 1'b1);
      chk("col_saturate", 32'(column), 32'hFE);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
